// File: rtl/snn_pkg.sv
// Shared types for the SNN run scheduler: FSM state encoding and a busy decode helper.
package snn_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN_LO = 3'd2,
    S_RUN_HI = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } snn_run_state_t;

  function automatic logic state_is_busy(input snn_run_state_t st);
    logic b;
    case (st)
      S_CLEAR, S_RUN_LO, S_RUN_HI, S_DRAIN: b = 1'b1;
      default:                              b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/snn_run_scheduler.sv
// Sequences one SNN inference run: clear the network, step timesteps with a
// two-cycle spike strobe, drain the output counters, then report done.
module snn_run_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_OUTPUTS            = 4,
  parameter int OUTPUT_SPIKE_ADDR_BITS = 4,
  parameter int MAX_TIMESTEPS_BITS     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic [31:0]                       sim_time,
  output logic                              network_rst,
  output logic                              spike_en,
  output logic [MAX_TIMESTEPS_BITS-1:0]     pattern_addr,
  output logic [31:0]                       timestep,
  output logic [OUTPUT_SPIKE_ADDR_BITS-1:0] drain_addr,
  output logic                              drain_wen,
  output logic                              mem_grant,
  output logic                              busy,
  output logic                              done
);

  snn_run_state_t                    r_state;
  snn_run_state_t                    w_next_state;
  logic                              r_start_q;
  logic [31:0]                       r_sim_time;
  logic [31:0]                       r_timestep;
  logic [OUTPUT_SPIKE_ADDR_BITS-1:0] r_drain_addr;

  logic w_start_evt;
  logic w_start_accept;
  logic w_last_step;
  logic w_last_drain;

  assign w_start_evt    = start & ~r_start_q;
  // Abort wins over a coincident start; starts only count between runs.
  assign w_start_accept = w_start_evt & ~abort &
                          ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_last_step    = ((r_timestep + 32'd1) == r_sim_time);
  assign w_last_drain   = (r_drain_addr == OUTPUT_SPIKE_ADDR_BITS'(NUM_OUTPUTS - 1));

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_next_state = w_start_accept ? S_CLEAR : S_IDLE;
        S_CLEAR:  w_next_state = (r_sim_time == 32'd0) ? S_DRAIN : S_RUN_LO;
        S_RUN_LO: w_next_state = S_RUN_HI;
        S_RUN_HI: w_next_state = w_last_step ? S_DRAIN : S_RUN_LO;
        S_DRAIN:  w_next_state = w_last_drain ? S_DONE : S_DRAIN;
        S_DONE:   w_next_state = w_start_accept ? S_CLEAR : S_DONE;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_q    <= 1'b0;
      r_sim_time   <= 32'd0;
      r_timestep   <= 32'd0;
      r_drain_addr <= '0;
    end else begin
      r_start_q <= start;
      if (w_start_accept) begin
        r_sim_time   <= sim_time;
        r_timestep   <= 32'd0;
        r_drain_addr <= '0;
      end else begin
        if (r_state == S_RUN_HI) begin
          r_timestep <= r_timestep + 32'd1;
        end
        if ((r_state == S_DRAIN) && !w_last_drain) begin
          r_drain_addr <= r_drain_addr + OUTPUT_SPIKE_ADDR_BITS'(1);
        end
      end
    end
  end

  assign network_rst  = (r_state == S_CLEAR);
  assign spike_en     = (r_state == S_RUN_HI);
  assign drain_wen    = (r_state == S_DRAIN);
  assign done         = (r_state == S_DONE);
  assign busy         = state_is_busy(r_state);
  assign mem_grant    = ~busy;
  assign pattern_addr = r_timestep[MAX_TIMESTEPS_BITS-1:0];
  assign timestep     = r_timestep;
  assign drain_addr   = r_drain_addr;

endmodule

// File: tb/tb_snn_run_scheduler.sv
// Directed self-checking bench for snn_run_scheduler (default instance plus a
// 2-bit pattern address instance for wrap behaviour).
module tb_snn_run_scheduler;
  import snn_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [31:0] sim_time;
  logic        a_network_rst, a_spike_en, a_drain_wen, a_mem_grant, a_busy, a_done;
  logic [7:0]  a_pattern_addr;
  logic [31:0] a_timestep;
  logic [3:0]  a_drain_addr;

  logic        start_w, abort_w;
  logic [31:0] sim_time_w;
  logic        b_network_rst, b_spike_en, b_drain_wen, b_mem_grant, b_busy, b_done;
  logic [1:0]  b_pattern_addr;
  logic [31:0] b_timestep;
  logic [3:0]  b_drain_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snn_run_scheduler #(.NUM_OUTPUTS(4), .OUTPUT_SPIKE_ADDR_BITS(4), .MAX_TIMESTEPS_BITS(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sim_time(sim_time),
    .network_rst(a_network_rst), .spike_en(a_spike_en), .pattern_addr(a_pattern_addr),
    .timestep(a_timestep), .drain_addr(a_drain_addr), .drain_wen(a_drain_wen),
    .mem_grant(a_mem_grant), .busy(a_busy), .done(a_done)
  );

  snn_run_scheduler #(.NUM_OUTPUTS(4), .OUTPUT_SPIKE_ADDR_BITS(4), .MAX_TIMESTEPS_BITS(2)) u_dut_wrap (
    .clk(clk), .rst(rst), .start(start_w), .abort(abort_w), .sim_time(sim_time_w),
    .network_rst(b_network_rst), .spike_en(b_spike_en), .pattern_addr(b_pattern_addr),
    .timestep(b_timestep), .drain_addr(b_drain_addr), .drain_wen(b_drain_wen),
    .mem_grant(b_mem_grant), .busy(b_busy), .done(b_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {network_rst, spike_en, drain_wen, busy, done, mem_grant}
  function automatic logic [5:0] ctl_a();
    return {a_network_rst, a_spike_en, a_drain_wen, a_busy, a_done, a_mem_grant};
  endfunction

  initial begin
    int cnt_spk;
    int cnt_wen;
    int cnt_nrst;
    int k;
    logic [1:0] wrap_seen [$];
    logic [1:0] wrap_exp [6];
    logic [5:0] exp_ctl;

    rst = 1'b1; start = 1'b0; abort = 1'b0; sim_time = 32'd0;
    start_w = 1'b0; abort_w = 1'b0; sim_time_w = 32'd0;
    tick(); tick();
    check_eq("rst_ctl", 64'(ctl_a()), 64'(6'b000001));
    check_eq("rst_timestep", 64'(a_timestep), 64'd0);
    check_eq("rst_drain_addr", 64'(a_drain_addr), 64'd0);
    rst = 1'b0;
    tick();

    // Nominal run, start held high for the whole run and beyond.
    sim_time = 32'd3; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_ctl = {(c == 1), (c == 3 || c == 5 || c == 7), (c >= 8 && c <= 11),
                 (c <= 11), (c == 12), (c == 12)};
      check_eq($sformatf("nom_ctl_c%0d", c), 64'(ctl_a()), 64'(exp_ctl));
      if (c == 3 || c == 5 || c == 7)
        check_eq($sformatf("nom_paddr_c%0d", c), 64'(a_pattern_addr), 64'((c - 3) / 2));
      if (c >= 8 && c <= 11)
        check_eq($sformatf("nom_daddr_c%0d", c), 64'(a_drain_addr), 64'(c - 8));
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("held_start_done", 64'({a_done, a_busy}), 64'(2'b10));
      check_eq("held_start_ts", 64'(a_timestep), 64'd3);
    end

    // Start toggled mid-run is ignored: sim_time=2 gives exactly two strobes.
    start = 1'b0; tick();
    sim_time = 32'd2; start = 1'b1;
    cnt_spk = 0; cnt_nrst = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 2) start = 1'b0;
      if (c == 3) start = 1'b1;
      if (a_spike_en) cnt_spk++;
      if (a_network_rst) cnt_nrst++;
    end
    check_eq("toggle_spikes", 64'(cnt_spk), 64'd2);
    check_eq("toggle_clears", 64'(cnt_nrst), 64'd1);
    check_eq("toggle_done", 64'(a_done), 64'd1);
    check_eq("toggle_ts", 64'(a_timestep), 64'd2);

    // Start event in DONE launches a zero-length run.
    start = 1'b0; sim_time = 32'd0; tick();
    start = 1'b1; tick();
    check_eq("restart_ctl", 64'(ctl_a()), 64'(6'b100100));
    check_eq("restart_ts", 64'(a_timestep), 64'd0);
    cnt_spk = 0;
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (a_spike_en) cnt_spk++;
      check_eq($sformatf("zero_wen_c%0d", c), 64'(a_drain_wen), 64'(c <= 5));
      if (c <= 5) check_eq($sformatf("zero_daddr_c%0d", c), 64'(a_drain_addr), 64'(c - 2));
    end
    check_eq("zero_spikes", 64'(cnt_spk), 64'd0);
    check_eq("zero_done", 64'(a_done), 64'd1);
    check_eq("zero_ts", 64'(a_timestep), 64'd0);

    // Abort in the second RUN_HI of a sim_time=10 run.
    start = 1'b0; tick();
    sim_time = 32'd10; start = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    check_eq("abort_pre_spike", 64'(a_spike_en), 64'd1);
    abort = 1'b1;
    tick();
    check_eq("abort_ctl", 64'(ctl_a()), 64'(6'b000001));
    abort = 1'b0;
    cnt_wen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (a_drain_wen || a_done) cnt_wen++;
    end
    check_eq("abort_no_drain", 64'(cnt_wen), 64'd0);

    // Abort in DONE wins over a coincident start event.
    start = 1'b0; sim_time = 32'd1; tick();
    start = 1'b1;
    for (int c = 1; c <= 8; c++) tick();
    check_eq("abdone_pre_done", 64'(a_done), 64'd1);
    check_eq("abdone_pre_ts", 64'(a_timestep), 64'd1);
    start = 1'b0; tick();
    start = 1'b1; abort = 1'b1; tick();
    check_eq("abdone_ctl", 64'(ctl_a()), 64'(6'b000001));
    abort = 1'b0; tick();
    check_eq("abdone_no_clear", 64'(ctl_a()), 64'(6'b000001));

    // Pattern address wrap on the 2-bit instance.
    wrap_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    sim_time_w = 32'd6; start_w = 1'b1;
    k = 0;
    while (k < 40 && !b_done) begin
      tick();
      if (b_spike_en) wrap_seen.push_back(b_pattern_addr);
      k++;
    end
    check_eq("wrap_reached_done", 64'(b_done), 64'd1);
    check_eq("wrap_count", 64'(wrap_seen.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < wrap_seen.size())
        check_eq($sformatf("wrap_paddr_%0d", i), 64'(wrap_seen[i]), 64'(wrap_exp[i]));
    check_eq("wrap_ts", 64'(b_timestep), 64'd6);
    check_eq("wrap_idle_ctl", 64'({b_network_rst, b_drain_wen, b_busy, b_mem_grant}), 64'(4'b0001));
    check_eq("wrap_daddr_final", 64'(b_drain_addr), 64'd3);

    // Asynchronous reset mid-drain at drain_addr=2.
    start = 1'b0; tick();
    sim_time = 32'd1; start = 1'b1;
    for (int c = 1; c <= 6; c++) tick();
    check_eq("rstd_pre_daddr", 64'(a_drain_addr), 64'd2);
    check_eq("rstd_pre_wen", 64'(a_drain_wen), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rstd_async_ctl", 64'(ctl_a()), 64'(6'b000001));
    check_eq("rstd_async_daddr", 64'(a_drain_addr), 64'd0);
    check_eq("rstd_async_ts", 64'(a_timestep), 64'd0);
    tick();
    start = 1'b0;
    rst = 1'b0;
    cnt_wen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (a_drain_wen) cnt_wen++;
    end
    check_eq("rstd_no_wen", 64'(cnt_wen), 64'd0);
    check_eq("rstd_idle_ctl", 64'(ctl_a()), 64'(6'b000001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
